// File: rtl/ysyx_22050243_lsu_ctrl.sv
// ysyx_22050243_lsu_ctrl
// MEM-stage load/store sequencer for the RV64 core. It takes one operation
// from EX/MEM, screens it for misalignment and illegal funct3, issues one
// 8-byte-aligned request with byte strobes and lane-shifted store data, then
// lane-shifts and extends the load data and hands the result to WB.
//
// Handshake semantics (all three ports: EX/MEM in, dmem req, WB out):
//   A transfer happens on a rising edge where valid and ready are both high.
//   A source holding valid high keeps every payload field stable until that
//   edge; valid never drops without a transfer. The dmem response has no
//   ready: it is a one-cycle pulse consumed only while waiting for it, and it
//   must arrive at least one cycle after the request transfer.
//
// All outputs come straight from flops. The control outputs are loaded from
// the next-state decode so they always agree with the state register.
module ysyx_22050243_lsu_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  // EX/MEM side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mem_r,
  input  logic             in_mem_w,
  input  logic [2:0]       in_funct3,
  input  logic [WIDTH-1:0] in_addr,
  input  logic [WIDTH-1:0] in_wdata,
  // data memory port
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [7:0]       dmem_wstrb,
  input  logic             dmem_rsp_valid,
  input  logic [WIDTH-1:0] dmem_rdata,
  // WB side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  // status
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Latched operation attributes needed after the request has gone out.
  logic       r_is_st;
  logic [2:0] r_funct3;
  logic [2:0] r_addr_lo;

  // Registered control outputs.
  logic r_in_ready;
  logic r_req_valid;
  logic r_out_valid;
  logic r_busy;

  // Registered payload outputs.
  logic             r_we;
  logic [WIDTH-1:0] r_dmem_addr;
  logic [WIDTH-1:0] r_dmem_wdata;
  logic [7:0]       r_dmem_wstrb;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_err;

  // Decode of the incoming operation.
  logic             w_is_st;
  logic             w_is_ld;
  logic             w_is_mem;
  logic             w_misalign;
  logic             w_bad_f3;
  logic             w_err;
  logic [7:0]       w_mask;
  logic [5:0]       w_st_shamt;
  logic [WIDTH-1:0] w_st_data;
  logic [7:0]       w_st_strb;

  // Load return path.
  logic [5:0]       w_ld_shamt;
  logic [WIDTH-1:0] w_ld_sh;
  logic [WIDTH-1:0] w_ld_ext;

  // Classify the operation on the input bus: kind, size, alignment, legality.
  always_comb begin
    w_is_st    = in_mem_w;
    w_is_ld    = in_mem_r & ~in_mem_w;
    w_is_mem   = in_mem_r | in_mem_w;
    w_misalign = 1'b0;
    w_mask     = 8'h01;
    case (in_funct3[1:0])
      2'b00: begin w_misalign = 1'b0;              w_mask = 8'h01; end
      2'b01: begin w_misalign = in_addr[0];        w_mask = 8'h03; end
      2'b10: begin w_misalign = |in_addr[1:0];     w_mask = 8'h0F; end
      default: begin w_misalign = |in_addr[2:0];   w_mask = 8'hFF; end
    endcase
    // Stores have no unsigned variants; 111 is the only unused load encoding.
    w_bad_f3   = w_is_st ? in_funct3[2] : (w_is_ld && (in_funct3 == 3'b111));
    w_err      = w_is_mem & (w_bad_f3 | w_misalign);
    w_st_shamt = {in_addr[2:0], 3'b000};
    w_st_data  = in_wdata << w_st_shamt;
    w_st_strb  = w_mask << in_addr[2:0];
  end

  // Bring the addressed bytes of the read beat down to bit 0 and extend them.
  always_comb begin
    w_ld_shamt = {r_addr_lo, 3'b000};
    w_ld_sh    = dmem_rdata >> w_ld_shamt;
    case (r_funct3)
      3'b000:  w_ld_ext = {{(WIDTH-8){w_ld_sh[7]}},   w_ld_sh[7:0]};
      3'b001:  w_ld_ext = {{(WIDTH-16){w_ld_sh[15]}}, w_ld_sh[15:0]};
      3'b010:  w_ld_ext = {{(WIDTH-32){w_ld_sh[31]}}, w_ld_sh[31:0]};
      3'b100:  w_ld_ext = {{(WIDTH-8){1'b0}},         w_ld_sh[7:0]};
      3'b101:  w_ld_ext = {{(WIDTH-16){1'b0}},        w_ld_sh[15:0]};
      3'b110:  w_ld_ext = {{(WIDTH-32){1'b0}},        w_ld_sh[31:0]};
      default: w_ld_ext = w_ld_sh;
    endcase
  end

  // Next-state decode; errors and no-ops bypass the memory entirely.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_err || !w_is_mem) w_next = S_RESP;
          else                    w_next = S_REQ;
        end
      end
      S_REQ:   if (dmem_req_ready) w_next = S_WAIT;
      S_WAIT:  if (dmem_rsp_valid) w_next = S_RESP;
      default: if (out_ready)      w_next = S_IDLE;
    endcase
  end

  // State register and the control outputs that follow it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_req_valid <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == S_IDLE);
      r_req_valid <= (w_next == S_REQ);
      r_out_valid <= (w_next == S_RESP);
      r_busy      <= (w_next != S_IDLE);
    end
  end

  // Payload registers: request fields load at accept and hold through REQ,
  // result fields load on entry to RESP and clear when WB takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_st      <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr_lo    <= 3'b000;
      r_we         <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_dmem_wstrb <= 8'h00;
      r_out_data   <= '0;
      r_out_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_is_st   <= w_is_st;
            r_funct3  <= in_funct3;
            r_addr_lo <= in_addr[2:0];
            if (w_is_mem && !w_err) begin
              r_we         <= w_is_st;
              r_dmem_addr  <= {in_addr[WIDTH-1:3], 3'b000};
              r_dmem_wdata <= w_st_data;
              r_dmem_wstrb <= w_is_st ? w_st_strb : 8'h00;
            end else begin
              r_out_data <= '0;
              r_out_err  <= w_err;
            end
          end
        end
        S_WAIT: begin
          if (dmem_rsp_valid) begin
            r_out_data <= r_is_st ? '0 : w_ld_ext;
            r_out_err  <= 1'b0;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            r_out_data <= '0;
            r_out_err  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready       = r_in_ready;
  assign dmem_req_valid = r_req_valid;
  assign dmem_we        = r_we;
  assign dmem_addr      = r_dmem_addr;
  assign dmem_wdata     = r_dmem_wdata;
  assign dmem_wstrb     = r_dmem_wstrb;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_err        = r_out_err;
  assign busy           = r_busy;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_ysyx_22050243_lsu_ctrl.sv
// Directed bench for ysyx_22050243_lsu_ctrl: load extension, store lanes,
// error/no-op bypass, backpressure on both sides and reset mid-operation.
module tb_ysyx_22050243_lsu_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_mem_r, in_mem_w;
  logic [2:0]  in_funct3;
  logic [63:0] in_addr, in_wdata;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rdata;
  logic        out_valid, out_ready, out_err, busy;
  logic [63:0] out_data;
  logic [1:0]  o_dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int req_cnt = 0;
  int req_base;

  ysyx_22050243_lsu_ctrl #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mem_r(in_mem_r),
    .in_mem_w(in_mem_w), .in_funct3(in_funct3), .in_addr(in_addr),
    .in_wdata(in_wdata),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .busy(busy), .o_dbg_state(o_dbg_state)
  );

  // Count request transfers seen on the memory port.
  always @(posedge clk) begin
    if (!rst && dmem_req_valid && dmem_req_ready) req_cnt++;
  end

  // Hard stop in case the sequence ever wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected $finish");
    $fatal(1);
  end

  // ---------------- check helpers ----------------
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic r, input logic w, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wdata);
    in_valid  = 1'b1;
    in_mem_r  = r;
    in_mem_w  = w;
    in_funct3 = f3;
    in_addr   = addr;
    in_wdata  = wdata;
  endtask

  // Best-case memory operation: ready at T+1, response at T+2, result at T+3.
  task automatic mem_best(input string tag, input logic r, input logic w,
                          input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] rdata,
                          input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                          input logic [7:0] exp_strb, input logic [63:0] exp_out);
    drive_op(r, w, f3, addr, wdata);
    chk1({tag, ".in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk1({tag, ".req_valid"}, dmem_req_valid, 1'b1);
    chk64({tag, ".addr"}, dmem_addr, exp_addr);
    chk1({tag, ".we"}, dmem_we, w);
    chk8({tag, ".wstrb"}, dmem_wstrb, exp_strb);
    if (w) chk64({tag, ".wdata"}, dmem_wdata, exp_wdata);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    chk1({tag, ".req_drop"}, dmem_req_valid, 1'b0);
    chk1({tag, ".no_early_out"}, out_valid, 1'b0);
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = rdata;
    tick();
    dmem_rsp_valid = 1'b0;
    chk1({tag, ".out_valid"}, out_valid, 1'b1);
    chk64({tag, ".out_data"}, out_data, exp_out);
    chk1({tag, ".out_err"}, out_err, 1'b0);
    chk1({tag, ".in_ready_resp"}, in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk1({tag, ".out_clear"}, out_valid, 1'b0);
    chk1({tag, ".back_idle"}, in_ready, 1'b1);
  endtask

  // Error or no-op: result at T+1, no memory request at any point.
  task automatic bypass(input string tag, input logic r, input logic w,
                        input logic [2:0] f3, input logic [63:0] addr,
                        input logic exp_err);
    req_base = req_cnt;
    drive_op(r, w, f3, addr, 64'h0123_4567_89AB_CDEF);
    tick();
    in_valid = 1'b0;
    chk1({tag, ".out_valid"}, out_valid, 1'b1);
    chk1({tag, ".out_err"}, out_err, exp_err);
    chk64({tag, ".out_data"}, out_data, 64'h0);
    chk1({tag, ".no_req"}, dmem_req_valid, 1'b0);
    dmem_req_ready = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    dmem_req_ready = 1'b0;
    chk1({tag, ".out_clear"}, out_valid, 1'b0);
    chk1({tag, ".err_clear"}, out_err, 1'b0);
    chk1({tag, ".no_req_after"}, dmem_req_valid, 1'b0);
    chk1({tag, ".req_count"}, (req_cnt == req_base), 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    chk1({tag, ".in_ready"}, in_ready, 1'b1);
    chk1({tag, ".busy"}, busy, 1'b0);
    chk1({tag, ".req_valid"}, dmem_req_valid, 1'b0);
    chk1({tag, ".we"}, dmem_we, 1'b0);
    chk64({tag, ".addr"}, dmem_addr, 64'h0);
    chk64({tag, ".wdata"}, dmem_wdata, 64'h0);
    chk8({tag, ".wstrb"}, dmem_wstrb, 8'h00);
    chk1({tag, ".out_valid"}, out_valid, 1'b0);
    chk64({tag, ".out_data"}, out_data, 64'h0);
    chk1({tag, ".out_err"}, out_err, 1'b0);
    chk8({tag, ".state"}, {6'd0, o_dbg_state}, 8'h00);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_mem_r = 1'b0; in_mem_w = 1'b0; in_funct3 = 3'b000;
    in_addr = 64'h0; in_wdata = 64'h0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = 64'h0;
    out_ready = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();
    check_reset_values("post_reset");

    // Loads: every funct3, various lanes.
    mem_best("lb",  1, 0, 3'b000, 64'h8000_0005, 64'h0, 64'h0011_8000_0000_0000,
             64'h8000_0000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80);
    mem_best("lhu", 1, 0, 3'b101, 64'h1006, 64'h0, 64'hBEEF_0000_0000_0000,
             64'h1000, 64'h0, 8'h00, 64'h0000_0000_0000_BEEF);
    mem_best("lw",  1, 0, 3'b010, 64'h1004, 64'h0, 64'h8000_0001_0000_0000,
             64'h1000, 64'h0, 8'h00, 64'hFFFF_FFFF_8000_0001);
    mem_best("lwu", 1, 0, 3'b110, 64'h1004, 64'h0, 64'h8000_0001_0000_0000,
             64'h1000, 64'h0, 8'h00, 64'h0000_0000_8000_0001);
    mem_best("lh",  1, 0, 3'b001, 64'h100E, 64'h0, 64'h8001_0000_0000_0000,
             64'h1008, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_8001);
    mem_best("ld",  1, 0, 3'b011, 64'h1010, 64'h0, 64'h0123_4567_89AB_CDEF,
             64'h1010, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF);
    mem_best("lbu", 1, 0, 3'b100, 64'h1013, 64'h0, 64'h0000_0000_F000_0000,
             64'h1010, 64'h0, 8'h00, 64'h0000_0000_0000_00F0);

    // Stores: lane shift and strobes; ack data must not leak to out_data.
    mem_best("sh", 0, 1, 3'b001, 64'h2002, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h2000, 64'h0000_0000_1234_0000, 8'h0C, 64'h0);
    mem_best("sb", 0, 1, 3'b000, 64'h2007, 64'hAB, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h2000, 64'hAB00_0000_0000_0000, 8'h80, 64'h0);
    mem_best("sd", 0, 1, 3'b011, 64'h2008, 64'h1122_3344_5566_7788, 64'h5A5A,
             64'h2008, 64'h1122_3344_5566_7788, 8'hFF, 64'h0);
    mem_best("sw", 0, 1, 3'b010, 64'h200C, 64'hCAFE_BABE, 64'h5A5A,
             64'h2008, 64'hCAFE_BABE_0000_0000, 8'hF0, 64'h0);
    mem_best("rw_prio", 1, 1, 3'b001, 64'h2002, 64'h5678, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h2000, 64'h0000_0000_5678_0000, 8'h0C, 64'h0);

    // Bypass paths.
    bypass("sw_mis",  0, 1, 3'b010, 64'h2002, 1'b1);
    bypass("ld_mis",  1, 0, 3'b011, 64'h2004, 1'b1);
    bypass("lh_mis",  1, 0, 3'b001, 64'h0001, 1'b1);
    bypass("st_f3",   0, 1, 3'b100, 64'h0000, 1'b1);
    bypass("ld_f3",   1, 0, 3'b111, 64'h0000, 1'b1);
    bypass("noop",    0, 0, 3'b111, 64'h0003, 1'b0);

    // Backpressure on the request, the response and the result.
    drive_op(1, 0, 3'b011, 64'h3008, 64'h0);
    tick();
    req_base = req_cnt;
    in_addr  = 64'hDEAD_0000;
    in_mem_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk1("bp_req.valid", dmem_req_valid, 1'b1);
      chk64("bp_req.addr", dmem_addr, 64'h3008);
      chk1("bp_req.we", dmem_we, 1'b0);
      chk8("bp_req.wstrb", dmem_wstrb, 8'h00);
      chk1("bp_req.in_ready", in_ready, 1'b0);
      chk1("bp_req.busy", busy, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    chk1("bp_req.valid_last", dmem_req_valid, 1'b1);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    chk1("bp_wait.out_valid", out_valid, 1'b0);
    tick();
    chk1("bp_wait2.out_valid", out_valid, 1'b0);
    chk1("bp_wait2.in_ready", in_ready, 1'b0);
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 64'hA5A5_5A5A_0F0F_F0F0;
    tick();
    dmem_rsp_valid = 1'b0;
    dmem_rdata     = 64'h0;
    in_valid       = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk1("bp_resp.valid", out_valid, 1'b1);
      chk64("bp_resp.data", out_data, 64'hA5A5_5A5A_0F0F_F0F0);
      chk1("bp_resp.in_ready", in_ready, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    chk1("bp_resp.valid_last", out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk1("bp_done.out_valid", out_valid, 1'b0);
    chk1("bp_done.in_ready", in_ready, 1'b1);
    chk1("bp_done.one_request", (req_cnt == req_base + 1), 1'b1);

    // Reset while waiting for the response; the late response is dropped.
    drive_op(1, 0, 3'b010, 64'h4000, 64'h0);
    tick();
    in_valid = 1'b0;
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    chk1("rst_wait.busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("rst_mid");
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    dmem_rsp_valid = 1'b0;
    chk1("late_rsp.out_valid", out_valid, 1'b0);
    chk1("late_rsp.busy", busy, 1'b0);
    tick();
    chk1("late_rsp2.out_valid", out_valid, 1'b0);
    chk64("late_rsp2.out_data", out_data, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
